// File: rtl/pp_pkg.sv
// Shared helpers for the history-indexed pattern predictor: counter init value,
// saturating step functions and the table index type.
package pp_pkg;

    typedef int unsigned pp_idx_t;

    // Weakly-not-taken start point: just below the MSB threshold.
    function automatic int ctr_init(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    function automatic int sat_inc(input int v, input int ctr_w);
        return (v >= (1 << ctr_w) - 1) ? v : v + 1;
    endfunction

    function automatic int sat_dec(input int v);
        return (v <= 0) ? v : v - 1;
    endfunction

endpackage

// File: rtl/pp_sat_ctr.sv
// One saturating prediction counter; the MSB is the predicted bit.
module pp_sat_ctr
    import pp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic dir_i,
    output logic msb_o
);

    localparam logic [CTR_W-1:0] INIT = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clr_i) begin
            ctr_d = INIT;
        end else if (en_i) begin
            ctr_d = dir_i ? CTR_W'(sat_inc(int'(ctr_q), CTR_W))
                          : CTR_W'(sat_dec(int'(ctr_q)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ctr_q <= INIT;
        else      ctr_q <= ctr_d;
    end

    assign msb_o = ctr_q[CTR_W-1];

endmodule

// File: rtl/pattern_predictor_hist.sv
// Serial-bit predictor: 2**HIST_W saturating counters indexed by recent history,
// plus hit statistics. Define PP_CLEAR_EN to add the synchronous clr port.
module pattern_predictor_hist
    import pp_pkg::*;
#(
    parameter int CTR_W  = 2,
    parameter int HIST_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_vld,
    input  logic             actual_pattern,
`ifdef PP_CLEAR_EN
    input  logic             clr,
`endif
    output logic             predicted_bit,
    output logic             z_match,
    output logic             match_vld,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] z_cnt
);

    localparam pp_idx_t DEPTH = pp_idx_t'(1) << HIST_W;

    logic              clr_eff;
    logic [DEPTH-1:0]  msb_vec;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]  x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]  z_cnt_q, z_cnt_d;
    logic              z_match_q, z_match_d;
    logic              match_vld_q, match_vld_d;
    logic              hit;

`ifdef PP_CLEAR_EN
    assign clr_eff = clr;
`else
    assign clr_eff = 1'b0;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        pp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clr_eff),
            .en_i  (sample_vld && !clr_eff && (hist_q == HIST_W'(g))),
            .dir_i (actual_pattern),
            .msb_o (msb_vec[g])
        );
    end

    assign predicted_bit = msb_vec[hist_q];
    assign hit           = (predicted_bit == actual_pattern);

    always_comb begin
        hist_d      = hist_q;
        x_cnt_d     = x_cnt_q;
        z_cnt_d     = z_cnt_q;
        z_match_d   = z_match_q;
        match_vld_d = 1'b0;
        if (clr_eff) begin
            hist_d    = '0;
            x_cnt_d   = '0;
            z_cnt_d   = '0;
            z_match_d = 1'b0;
        end else if (sample_vld) begin
            hist_d      = HIST_W'({hist_q, actual_pattern});
            z_match_d   = hit;
            match_vld_d = 1'b1;
            // Freeze both stats together so the hit ratio stays meaningful.
            if (x_cnt_q != '1) begin
                x_cnt_d = x_cnt_q + 1'b1;
                if (hit) z_cnt_d = z_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q      <= '0;
            x_cnt_q     <= '0;
            z_cnt_q     <= '0;
            z_match_q   <= 1'b0;
            match_vld_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            x_cnt_q     <= x_cnt_d;
            z_cnt_q     <= z_cnt_d;
            z_match_q   <= z_match_d;
            match_vld_q <= match_vld_d;
        end
    end

    assign z_match   = z_match_q;
    assign match_vld = match_vld_q;
    assign x_cnt     = x_cnt_q;
    assign z_cnt     = z_cnt_q;

endmodule

// File: tb/tb_pattern_predictor_hist.sv
// Scoreboard bench for pattern_predictor_hist (CTR_W=2, HIST_W=2, CNT_W=8).
module tb_pattern_predictor_hist;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_vld;
    logic             actual_pattern;
    logic             clr;
    logic             predicted_bit;
    logic             z_match;
    logic             match_vld;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] z_cnt;

    pattern_predictor_hist #(.CTR_W(2), .HIST_W(2), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_vld     (sample_vld),
        .actual_pattern (actual_pattern),
`ifdef PP_CLEAR_EN
        .clr            (clr),
`endif
        .predicted_bit  (predicted_bit),
        .z_match        (z_match),
        .match_vld      (match_vld),
        .x_cnt          (x_cnt),
        .z_cnt          (z_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hit;
        int x;
        int z;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: four 0..3 counters, history as an integer 0..3.
    int tbl[4];
    int m_hist, m_x, m_z, m_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_pred();
        return (tbl[m_hist] >= 2) ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) tbl[i] = 1;
        m_hist = 0;
        m_x = 0;
        m_z = 0;
        m_last = 0;
        exp_q.delete();
    endtask

    task automatic sample(input int a);
        int   p;
        exp_t e;
        @(negedge clk);
        sample_vld     = 1'b1;
        actual_pattern = a[0];
        p = m_pred();
        chk("predicted_bit", int'(predicted_bit), p);
        e.hit = (p == a) ? 1 : 0;
        tbl[m_hist] = a ? ((tbl[m_hist] < 3) ? tbl[m_hist] + 1 : 3)
                        : ((tbl[m_hist] > 0) ? tbl[m_hist] - 1 : 0);
        m_hist = ((m_hist * 2) + a) % 4;
        if (m_x < CNT_MAX) begin
            m_x++;
            if (e.hit == 1) m_z++;
        end
        m_last = e.hit;
        e.x = m_x;
        e.z = m_z;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit hold_chk);
        @(negedge clk);
        if (hold_chk) begin
            chk("gap_match_vld", int'(match_vld), 0);
            chk("gap_x_cnt", int'(x_cnt), m_x);
            chk("gap_z_cnt", int'(z_cnt), m_z);
            chk("gap_z_match", int'(z_match), m_last);
            chk("gap_predicted_bit", int'(predicted_bit), m_pred());
        end
        sample_vld     = 1'b0;
        actual_pattern = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_predicted_bit"}, int'(predicted_bit), 0);
        chk({tag, "_x_cnt"}, int'(x_cnt), 0);
        chk({tag, "_z_cnt"}, int'(z_cnt), 0);
        chk({tag, "_z_match"}, int'(z_match), 0);
        chk({tag, "_match_vld"}, int'(match_vld), 0);
    endtask

    // Async reset pulse between edges; outputs must clear before any edge.
    task automatic async_reset();
        @(negedge clk);
        sample_vld = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        m_reset();
        #1 rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && match_vld) begin
            if (exp_q.size() == 0) begin
                chk("match_vld_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("z_match", int'(z_match), e.hit);
                chk("x_cnt", int'(x_cnt), e.x);
                chk("z_cnt", int'(z_cnt), e.z);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        sample_vld     = 1'b0;
        actual_pattern = 1'b0;
        clr            = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        rst = 1'b1;

        // Constant ones
        for (int i = 0; i < 8; i++) sample(1);
        idle(1'b0);
        idle(1'b1);
        chk("ones_x_cnt", int'(x_cnt), 8);
        chk("ones_z_cnt", int'(z_cnt), 5);
        chk("ones_pred", int'(predicted_bit), 1);

        // Alternating from reset
        async_reset();
        for (int i = 0; i < 16; i++) sample(i % 2);
        idle(1'b0);
        idle(1'b1);
        chk("alt_x_cnt", int'(x_cnt), 16);
        chk("alt_z_cnt", int'(z_cnt), 14);

        // Gaps of 5 idle cycles between random samples
        async_reset();
        for (int i = 0; i < 6; i++) begin
            sample(int'($urandom_range(0, 1)));
            idle(1'b0);
            repeat (4) idle(1'b1);
        end

        // Async reset mid-stream, then the sequence restarts cleanly
        async_reset();
        for (int i = 0; i < 7; i++) sample(i % 2);
        idle(1'b0);
        async_reset();
        for (int i = 0; i < 16; i++) sample(i % 2);
        idle(1'b0);
        idle(1'b1);
        chk("restart_x_cnt", int'(x_cnt), 16);
        chk("restart_z_cnt", int'(z_cnt), 14);

        // Stats saturation
        async_reset();
        for (int i = 0; i < CNT_MAX + 45; i++) sample(1);
        idle(1'b0);
        idle(1'b1);
        chk("sat_x_cnt", int'(x_cnt), CNT_MAX);
        chk("sat_z_cnt", int'(z_cnt), CNT_MAX - 3);

        // Randomised mix of samples and gaps
        async_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) sample(($urandom_range(0, 3) != 0) ? 1 : 0);
            else idle(1'b0);
        end
        idle(1'b0);
        idle(1'b1);

`ifdef PP_CLEAR_EN
        // Synchronous clear wins over a coincident sample
        for (int i = 0; i < 5; i++) sample(1);
        idle(1'b0);
        @(negedge clk);
        clr            = 1'b1;
        sample_vld     = 1'b1;
        actual_pattern = 1'b1;
        m_reset();
        @(negedge clk);
        clr        = 1'b0;
        sample_vld = 1'b0;
        chk_zero("clr");
        for (int i = 0; i < 16; i++) sample(i % 2);
        idle(1'b0);
        idle(1'b1);
        chk("clr_alt_x_cnt", int'(x_cnt), 16);
        chk("clr_alt_z_cnt", int'(z_cnt), 14);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
